// File: rtl/m31_inv.sv
// M31 field inverter: a^(P-2) mod P, P = 2^31-1, by left-to-right square-and-multiply
// over one 4-cycle pipelined modular multiplier. One operand in flight, fixed latency.

module m31_mul (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [30:0] x_i,
    input  logic [30:0] y_i,
    output logic [30:0] p_o
);
    localparam logic [31:0] P32 = 32'h7FFF_FFFF;

    logic [30:0] x_q;
    logic [30:0] y_q;
    logic [61:0] prod_q;
    logic [31:0] sum_q;
    logic [30:0] res_q;

    // 2^31 == 1 mod P, so the high half folds onto the low half; the sum is below 2P.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            x_q    <= '0;
            y_q    <= '0;
            prod_q <= '0;
            sum_q  <= '0;
            res_q  <= '0;
        end else begin
            x_q    <= x_i;
            y_q    <= y_i;
            prod_q <= 62'(x_q) * 62'(y_q);
            sum_q  <= {1'b0, prod_q[30:0]} + {1'b0, prod_q[61:31]};
            res_q  <= (sum_q >= P32) ? 31'(sum_q - P32) : sum_q[30:0];
        end
    end

    assign p_o = res_q;
endmodule

module m31_inv #(
    parameter int LATENCY = 240
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [30:0] in_a,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [30:0] out_inv,
    output logic        out_zero
);
    typedef logic [30:0] m31_t;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    typedef enum logic [1:0] {PH_SQR, PH_MUL, PH_CAP, PH_END} phase_t;

    localparam m31_t       EXP   = 31'h7FFF_FFFD;
    localparam m31_t       P     = 31'h7FFF_FFFF;
    localparam logic [7:0] LAST  = 8'(LATENCY - 1);

    state_t     state_q, state_d;
    phase_t     phase_q, phase_d;
    logic [7:0] cyc_q, cyc_d;
    logic [4:0] bit_q, bit_d;
    logic [1:0] wait_q, wait_d;
    logic       first_q, first_d;
    m31_t       a_q, a_d;
    m31_t       res_q, res_d;
    m31_t       out_inv_q, out_inv_d;
    logic       out_zero_q, out_zero_d;

    logic       mul_rst_n;
    m31_t       mul_x;
    m31_t       mul_y;
    m31_t       mul_p;

    // The first operation uses a directly; later ones take the product straight off the multiplier.
    assign mul_x     = first_q ? a_q : mul_p;
    assign mul_y     = (phase_q == PH_SQR) ? mul_x : a_q;
    assign mul_rst_n = ~rst;

    m31_mul u_mul (
        .clk   (clk),
        .rst_n (mul_rst_n),
        .x_i   (mul_x),
        .y_i   (mul_y),
        .p_o   (mul_p)
    );

    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        cyc_d      = cyc_q;
        bit_d      = bit_q;
        wait_d     = wait_q;
        first_d    = first_q;
        a_d        = a_q;
        res_d      = res_q;
        out_inv_d  = out_inv_q;
        out_zero_d = out_zero_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d = RUN;
                    a_d     = (in_a == P) ? '0 : in_a;
                    cyc_d   = '0;
                    bit_d   = 5'd29;
                    phase_d = PH_SQR;
                    wait_d  = '0;
                    first_d = 1'b1;
                end
            end
            RUN: begin
                cyc_d  = cyc_q + 8'd1;
                wait_d = wait_q + 2'd1;
                // An operation issues (or the final product is captured) every fourth cycle.
                if (wait_q == 2'd0) begin
                    case (phase_q)
                        PH_SQR: begin
                            first_d = 1'b0;
                            if (EXP[bit_q]) begin
                                phase_d = PH_MUL;
                            end else begin
                                bit_d = bit_q - 5'd1;
                            end
                        end
                        PH_MUL: begin
                            if (bit_q == 5'd0) begin
                                phase_d = PH_CAP;
                            end else begin
                                bit_d   = bit_q - 5'd1;
                                phase_d = PH_SQR;
                            end
                        end
                        PH_CAP: begin
                            res_d   = mul_p;
                            phase_d = PH_END;
                        end
                        default: ;
                    endcase
                end
                if (cyc_q == LAST) begin
                    state_d    = DONE;
                    out_inv_d  = res_q;
                    out_zero_d = (a_q == '0);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d    = IDLE;
                    out_inv_d  = '0;
                    out_zero_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            phase_q    <= PH_SQR;
            cyc_q      <= '0;
            bit_q      <= '0;
            wait_q     <= '0;
            first_q    <= 1'b0;
            a_q        <= '0;
            res_q      <= '0;
            out_inv_q  <= '0;
            out_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            cyc_q      <= cyc_d;
            bit_q      <= bit_d;
            wait_q     <= wait_d;
            first_q    <= first_d;
            a_q        <= a_d;
            res_q      <= res_d;
            out_inv_q  <= out_inv_d;
            out_zero_q <= out_zero_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign out_inv   = out_inv_q;
    assign out_zero  = out_zero_q;
endmodule

// File: tb/tb_m31_inv.sv
// Bench for m31_inv: inverses checked against a right-to-left modular exponentiation
// model and the Fermat identity a*inv == 1, plus latency, backpressure and reset scenarios.

module tb_m31_inv;
    localparam longint unsigned PL = 64'h7FFF_FFFF;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [30:0] in_a;
    logic        out_valid;
    logic        out_ready;
    logic [30:0] out_inv;
    logic        out_zero;

    int tests_run;
    int fails;
    logic [30:0] exp_q[$];

    m31_inv dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_inv   (out_inv),
        .out_zero  (out_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [30:0] ref_inv(input logic [30:0] a);
        longint unsigned base;
        longint unsigned r;
        longint unsigned e;
        base = (64'(a) == PL) ? 64'd0 : 64'(a);
        r    = 64'd1;
        e    = PL - 64'd2;
        while (e != 0) begin
            if (e[0]) r = (r * base) % PL;
            base = (base * base) % PL;
            e    = e >> 1;
        end
        return 31'(r);
    endfunction

    function automatic longint unsigned fermat(input logic [30:0] a, input logic [30:0] inv);
        return (64'(a) * 64'(inv)) % PL;
    endfunction

    // Presents one operand, waits for its accept edge, returns edges until out_valid is seen.
    task automatic run_op(input logic [30:0] a, output int lat);
        lat = -1;
        @(negedge clk);
        in_a     = a;
        in_valid = 1'b1;
        for (int w = 0; w < 600 && !in_ready; w++) @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        in_a     = 31'($urandom);
        for (int n = 1; n <= 400; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (out_valid) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        in_a = '0;
        out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        tests_run++;
        if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        tests_run++;
        if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        tests_run++;
        if (out_inv !== 31'd0) begin fails++; $display("FAIL reset_out_inv got=%h exp=0", out_inv); end
        tests_run++;
        if (out_zero !== 1'b0) begin fails++; $display("FAIL reset_out_zero got=%b exp=0", out_zero); end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_basic();
        logic [30:0] ops[4];
        logic [30:0] exps[4];
        int lat;
        ops[0] = 31'd1;          exps[0] = 31'd1;
        ops[1] = 31'd2;          exps[1] = 31'h4000_0000;
        ops[2] = 31'h7FFF_FFFE;  exps[2] = 31'h7FFF_FFFE;
        ops[3] = 31'd3;          exps[3] = 31'h5555_5555;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            run_op(ops[i], lat);
            tests_run++;
            if (lat !== 240) begin fails++; $display("FAIL basic_latency a=%h got=%0d exp=240", ops[i], lat); end
            tests_run++;
            if (out_inv !== exps[i]) begin fails++; $display("FAIL basic_inv a=%h got=%h exp=%h", ops[i], out_inv, exps[i]); end
            tests_run++;
            if (out_inv !== ref_inv(ops[i])) begin fails++; $display("FAIL basic_model a=%h got=%h exp=%h", ops[i], out_inv, ref_inv(ops[i])); end
            tests_run++;
            if (out_zero !== 1'b0) begin fails++; $display("FAIL basic_zero a=%h got=%b exp=0", ops[i], out_zero); end
            @(posedge clk);
            @(negedge clk);
            tests_run++;
            if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
                fails++; $display("FAIL basic_after_hs in_ready=%b out_valid=%b exp 1/0", in_ready, out_valid);
            end
        end
    endtask

    task automatic test_zero();
        logic [30:0] ops[2];
        int lat;
        ops[0] = 31'd0;
        ops[1] = 31'h7FFF_FFFF;
        out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            run_op(ops[i], lat);
            tests_run++;
            if (lat !== 240) begin fails++; $display("FAIL zero_latency a=%h got=%0d exp=240", ops[i], lat); end
            tests_run++;
            if (out_inv !== 31'd0) begin fails++; $display("FAIL zero_inv a=%h got=%h exp=0", ops[i], out_inv); end
            tests_run++;
            if (out_zero !== 1'b1) begin fails++; $display("FAIL zero_flag a=%h got=%b exp=1", ops[i], out_zero); end
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic test_random();
        logic [30:0] a;
        logic [30:0] e;
        int lat;
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            a = 31'($urandom_range(1, 32'h7FFF_FFFE));
            e = ref_inv(a);
            run_op(a, lat);
            tests_run++;
            if (lat !== 240) begin fails++; $display("FAIL rand_latency a=%h got=%0d exp=240", a, lat); end
            tests_run++;
            if (out_inv !== e) begin fails++; $display("FAIL rand_inv a=%h got=%h exp=%h", a, out_inv, e); end
            tests_run++;
            if (fermat(a, out_inv) !== 64'd1) begin
                fails++; $display("FAIL rand_fermat a=%h inv=%h prod_mod=%0d exp=1", a, out_inv, fermat(a, out_inv));
            end
            tests_run++;
            if (out_zero !== 1'b0) begin fails++; $display("FAIL rand_zero a=%h got=%b exp=0", a, out_zero); end
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic test_backpressure();
        logic [30:0] a;
        logic [30:0] e;
        int lat;
        int bad;
        a = 31'd7;
        e = ref_inv(a);
        out_ready = 1'b0;
        run_op(a, lat);
        tests_run++;
        if (lat !== 240) begin fails++; $display("FAIL bp_latency got=%0d exp=240", lat); end
        bad = 0;
        for (int c = 0; c < 50; c++) begin
            if (c == 10) begin in_valid = 1'b1; in_a = 31'd0; end
            if (c == 11) in_valid = 1'b0;
            @(posedge clk);
            @(negedge clk);
            tests_run++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_inv !== e || out_zero !== 1'b0) begin
                fails++;
                $display("FAIL bp_hold cycle=%0d out_valid=%b in_ready=%b inv=%h zero=%b exp 1/0/%h/0",
                         c, out_valid, in_ready, out_inv, out_zero, e);
            end
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        tests_run++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            fails++; $display("FAIL bp_release out_valid=%b in_ready=%b exp 0/1", out_valid, in_ready);
        end
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (out_valid !== 1'b0 || in_ready !== 1'b1) bad++;
        end
        tests_run++;
        if (bad !== 0) begin fails++; $display("FAIL bp_no_phantom bad_cycles=%0d exp=0", bad); end
    endtask

    task automatic test_reset_mid();
        int lat;
        out_ready = 1'b1;
        @(negedge clk);
        in_a = 31'd5;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        for (int i = 1; i < 100; i++) begin
            @(posedge clk);
            @(negedge clk);
        end
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        tests_run++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_inv !== 31'd0 || out_zero !== 1'b0) begin
            fails++;
            $display("FAIL midrst_state in_ready=%b out_valid=%b inv=%h zero=%b exp 1/0/0/0",
                     in_ready, out_valid, out_inv, out_zero);
        end
        run_op(31'd3, lat);
        tests_run++;
        if (lat !== 240) begin fails++; $display("FAIL midrst_latency got=%0d exp=240", lat); end
        tests_run++;
        if (out_inv !== 31'h5555_5555) begin fails++; $display("FAIL midrst_inv got=%h exp=55555555", out_inv); end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [30:0] ops[4];
        logic [30:0] e;
        int k;
        int got;
        int edge_n;
        int last_acc;
        bit acc;
        bit hs;
        for (int i = 0; i < 4; i++) ops[i] = 31'($urandom_range(1, 32'h7FFF_FFFE));
        k = 0;
        got = 0;
        edge_n = 0;
        last_acc = -1;
        out_ready = 1'b1;
        @(negedge clk);
        in_a = ops[0];
        in_valid = 1'b1;
        while (got < 4 && edge_n < 2000) begin
            acc = in_valid && in_ready;
            hs  = out_valid && out_ready;
            if (hs) begin
                tests_run++;
                if (exp_q.size() == 0) begin
                    fails++; $display("FAIL b2b_extra_result got=%h", out_inv);
                end else begin
                    e = exp_q.pop_front();
                    if (out_inv !== e) begin fails++; $display("FAIL b2b_inv idx=%0d got=%h exp=%h", got, out_inv, e); end
                end
                got++;
            end
            if (acc) begin
                tests_run++;
                if (exp_q.size() != 0) begin fails++; $display("FAIL b2b_overlap inflight=%0d exp=0", exp_q.size()); end
                if (last_acc >= 0) begin
                    tests_run++;
                    if (edge_n + 1 - last_acc != 242) begin
                        fails++; $display("FAIL b2b_gap got=%0d exp=242", edge_n + 1 - last_acc);
                    end
                end
                last_acc = edge_n + 1;
                exp_q.push_back(ref_inv(ops[k]));
            end
            @(posedge clk);
            edge_n++;
            @(negedge clk);
            if (acc) begin
                k++;
                if (k < 4) in_a = ops[k];
                else in_valid = 1'b0;
            end
        end
        in_valid = 1'b0;
        tests_run++;
        if (got !== 4 || k !== 4) begin fails++; $display("FAIL b2b_count results=%0d accepts=%0d exp=4/4", got, k); end
        tests_run++;
        if (exp_q.size() !== 0) begin fails++; $display("FAIL b2b_leftover got=%0d exp=0", exp_q.size()); end
    endtask

    initial begin
        tests_run = 0;
        fails = 0;
        test_reset();
        test_basic();
        test_zero();
        test_random();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end
endmodule
